// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Controls an in-order pipeline that has NSTAGE stages. The block tracks which
// stages hold a valid instruction and works out the stall back-pressure from
// the per-stage stall requests. It also handles flushes, counts stall and
// retire events, and runs a watchdog that raises a sticky flag when the last
// stage stays stalled for too long.
//
// Parameters
//   NSTAGE  number of pipeline stages (2..8)
//   CNT_W   width of the performance counters
//   TMO     stall-timeout threshold in cycles; 0 disables the watchdog
//
// Ports
//   clk          in   sole clock, rising edge
//   rstn         in   asynchronous active-low reset
//   fetch_valid  in   a new instruction is offered to stage 0
//   stall_req    in   bit i: stage i cannot complete this cycle
//   flush_req    in   flush stages 0..flush_upto
//   flush_upto   in   oldest stage included in the flush (clamped to NSTAGE-1)
//   cnt_clr      in   synchronous clear of both counters
//   fetch_ready  out  stage 0 accepts fetch_valid this cycle
//   stage_en     out  bit i: stage i input register loads this cycle
//   bubble       out  bit i: stage i loads a bubble (control fields zeroed)
//   stage_valid  out  bit i: stage i holds a valid instruction
//   retire       out  a valid instruction leaves stage NSTAGE-1 this cycle
//   stall_cycles out  cycles on which a fetch was offered but stage 0 was held
//                     (saturating)
//   retired_cnt  out  number of retired instructions (wrapping)
//   stall_tmo    out  sticky watchdog flag
//
// Fetch handshake: an instruction transfers into stage 0 on a rising edge
// where fetch_valid and fetch_ready are both high. fetch_valid may be raised
// without waiting for fetch_ready. A flush in the same cycle discards the
// offered instruction, because the flush redirects the front end anyway.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter  int NSTAGE = 5,
    parameter  int CNT_W  = 32,
    parameter  int TMO    = 255,
    localparam int FW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_valid,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_req,
    input  logic [FW-1:0]     flush_upto,
    input  logic              cnt_clr,
    output logic              fetch_ready,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              retire,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic              stall_tmo
);

    // The watchdog count only has to reach TMO-1. The flag is set on the held
    // cycle that finds the count already at TMO-1, which is the TMO-th
    // consecutive held cycle.
    localparam int          TW      = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] valid_d;
    logic [NSTAGE-1:0] held;
    logic [NSTAGE-1:0] flushed;
    logic [NSTAGE-1:0] in_valid;
    logic [FW-1:0]     upto_c;
    logic [TW-1:0]     wd_cnt;

    assign stage_valid = valid_q;

    // A flush bound beyond the last stage means "flush everything".
    always_comb begin
        upto_c = flush_upto;
        if (int'(flush_upto) >= NSTAGE) begin
            upto_c = FW'(NSTAGE - 1);
        end
    end

    // The hold chain runs from the oldest stage to the youngest. An empty
    // stage is never held, so a bubble soaks up back-pressure from above it
    // and the stall_req of an empty stage is ignored. A running variable
    // carries the chain, which keeps held[] free of self-reference.
    always_comb begin : p_held
        logic h;
        h    = 1'b0;
        held = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            h       = valid_q[i] & (stall_req[i] | h);
            held[i] = h;
        end
    end

    always_comb begin
        flushed = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            flushed[i] = flush_req && (i <= int'(upto_c));
        end
    end

    // in_valid[i] is the valid bit that stage i would load this cycle. The
    // stage just above the flushed range is fed from a flushed stage, so it
    // receives a bubble. Gating stage 0 with rstn keeps bubble[0] high while
    // reset is asserted, even if fetch_valid is high.
    always_comb begin
        in_valid    = '0;
        in_valid[0] = fetch_valid & rstn;
        for (int i = 1; i < NSTAGE; i++) begin
            in_valid[i] = valid_q[i-1] & ~held[i-1] & ~flushed[i-1];
        end
    end

    // A flushed stage always loads a bubble, even when the hold chain would
    // otherwise freeze it. For that reason its enable is forced on.
    always_comb begin
        stage_en    = ~held | flushed;
        bubble      = flushed | (stage_en & ~in_valid);
        fetch_ready = ~held[0];
        retire      = valid_q[NSTAGE-1] & ~stall_req[NSTAGE-1] & ~flushed[NSTAGE-1];
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NSTAGE; i++) begin
            if (flushed[i]) begin
                valid_d[i] = 1'b0;
            end else if (!held[i]) begin
                valid_d[i] = in_valid[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Performance counters. A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            retired_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            retired_cnt  <= '0;
        end else begin
            if (held[0] && fetch_valid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

    // Watchdog on the oldest stage. Any cycle in which the oldest stage is
    // not held restarts the count. Once the flag is set, only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt    <= '0;
            stall_tmo <= 1'b0;
        end else if (TMO != 0) begin
            if (held[NSTAGE-1]) begin
                if (wd_cnt != WD_LAST) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end else begin
                    stall_tmo <= 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed testbench for pipe_ctrl, built with NSTAGE=5, CNT_W=16 and TMO=4.
// Each vector drives one cycle of inputs and pushes that cycle's expected
// observation, worked out by hand. The observation covers stage_valid,
// stage_en, bubble, fetch_ready, retire, stall_tmo and both counters. A
// monitor on the falling edge pops each entry and compares it with the live
// outputs.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int W = 50;

    logic        clk;
    logic        rstn;
    logic        fetch_valid;
    logic [4:0]  stall_req;
    logic        flush_req;
    logic [2:0]  flush_upto;
    logic        cnt_clr;
    logic        fetch_ready;
    logic [4:0]  stage_en;
    logic [4:0]  bubble;
    logic [4:0]  stage_valid;
    logic        retire;
    logic [15:0] stall_cycles;
    logic [15:0] retired_cnt;
    logic        stall_tmo;

    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           vec_n  = 0;
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] obs;
    logic [W-1:0] mon_e;
    int           mon_id;

    pipe_ctrl #(.NSTAGE(5), .CNT_W(16), .TMO(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fetch_valid  (fetch_valid),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .flush_upto   (flush_upto),
        .cnt_clr      (cnt_clr),
        .fetch_ready  (fetch_ready),
        .stage_en     (stage_en),
        .bubble       (bubble),
        .stage_valid  (stage_valid),
        .retire       (retire),
        .stall_cycles (stall_cycles),
        .retired_cnt  (retired_cnt),
        .stall_tmo    (stall_tmo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {stage_valid, stage_en, bubble, fetch_ready, retire, stall_tmo,
                  stall_cycles, retired_cnt};

    // ---------------- driver tasks ----------------
    task automatic drv(input logic fv, input logic [4:0] st, input logic fl,
                       input logic [2:0] up, input logic clr);
        @(posedge clk);
        #1;
        fetch_valid = fv;
        stall_req   = st;
        flush_req   = fl;
        flush_upto  = up;
        cnt_clr     = clr;
        vec_n++;
    endtask

    task automatic chk(input logic [4:0] sv, input logic [4:0] en, input logic [4:0] bub,
                       input logic fr, input logic ret, input logic tmo,
                       input logic [15:0] sc, input logic [15:0] rc);
        exp_q.push_back({sv, en, bub, fr, ret, tmo, sc, rc});
        id_q.push_back(vec_n);
    endtask

    // Five fetches into an empty pipe, with no stalls.
    task automatic fill5(input logic [15:0] sc, input logic [15:0] rc);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1E, 1'b1, 1'b0, 1'b0, sc, rc);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h01, 5'h1F, 5'h1C, 1'b1, 1'b0, 1'b0, sc, rc);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h03, 5'h1F, 5'h18, 1'b1, 1'b0, 1'b0, sc, rc);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h07, 5'h1F, 5'h10, 1'b1, 1'b0, 1'b0, sc, rc);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h0F, 5'h1F, 5'h00, 1'b1, 1'b0, 1'b0, sc, rc);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_id = id_q.pop_front();
            checks++;
            if (obs !== mon_e) begin
                errors++;
                $display("FAIL vec%0d: got sv=%b en=%b bub=%b fr=%b ret=%b tmo=%b sc=%0d rc=%0d; expected sv=%b en=%b bub=%b fr=%b ret=%b tmo=%b sc=%0d rc=%0d",
                         mon_id, obs[49:45], obs[44:40], obs[39:35], obs[34], obs[33], obs[32],
                         obs[31:16], obs[15:0],
                         mon_e[49:45], mon_e[44:40], mon_e[39:35], mon_e[34], mon_e[33], mon_e[32],
                         mon_e[31:16], mon_e[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn        = 1'b0;
        fetch_valid = 1'b1;
        stall_req   = '0;
        flush_req   = 1'b0;
        flush_upto  = '0;
        cnt_clr     = 1'b0;

        // Reset state. fetch_valid is held high on purpose.
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        #1;
        fetch_valid = 1'b0;
        rstn        = 1'b1;

        // Ten fetches with no stalls: first retire 5 cycles after the first fetch.
        fill5(16'd0, 16'd0);
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0);
            chk(5'h1F, 5'h1F, 5'h00, 1'b1, 1'b1, 1'b0, 16'd0, 16'(k));
        end
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h1F, 5'h01, 1'b1, 1'b1, 1'b0, 16'd0, 16'd5);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1E, 5'h1F, 5'h03, 1'b1, 1'b1, 1'b0, 16'd0, 16'd6);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1C, 5'h1F, 5'h07, 1'b1, 1'b1, 1'b0, 16'd0, 16'd7);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h18, 5'h1F, 5'h0F, 1'b1, 1'b1, 1'b0, 16'd0, 16'd8);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h10, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b0, 16'd0, 16'd9);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd10);

        // Full pipe, stall_req[2] high for 3 cycles.
        fill5(16'd0, 16'd10);
        drv(1'b1, 5'h04, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h18, 5'h08, 1'b0, 1'b1, 1'b0, 16'd0, 16'd10);
        drv(1'b1, 5'h04, 1'b0, 3'd0, 1'b0); chk(5'h17, 5'h18, 5'h18, 1'b0, 1'b1, 1'b0, 16'd1, 16'd11);
        drv(1'b1, 5'h04, 1'b0, 3'd0, 1'b0); chk(5'h07, 5'h18, 5'h18, 1'b0, 1'b0, 1'b0, 16'd2, 16'd12);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h07, 5'h1F, 5'h11, 1'b1, 1'b0, 1'b0, 16'd3, 16'd12);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h0E, 5'h1F, 5'h03, 1'b1, 1'b0, 1'b0, 16'd3, 16'd12);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1C, 5'h1F, 5'h07, 1'b1, 1'b1, 1'b0, 16'd3, 16'd12);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h18, 5'h1F, 5'h0F, 1'b1, 1'b1, 1'b0, 16'd3, 16'd13);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h10, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b0, 16'd3, 16'd14);

        // Only stage 4 valid, with stall_req[1] high: the stall collapses on the empty stage.
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1E, 1'b1, 1'b0, 1'b0, 16'd3, 16'd15);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h01, 5'h1F, 5'h1D, 1'b1, 1'b0, 1'b0, 16'd3, 16'd15);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h02, 5'h1F, 5'h1B, 1'b1, 1'b0, 1'b0, 16'd3, 16'd15);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h04, 5'h1F, 5'h17, 1'b1, 1'b0, 1'b0, 16'd3, 16'd15);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h08, 5'h1F, 5'h0F, 1'b1, 1'b0, 1'b0, 16'd3, 16'd15);
        drv(1'b1, 5'h02, 1'b0, 3'd0, 1'b0); chk(5'h10, 5'h1F, 5'h1E, 1'b1, 1'b1, 1'b0, 16'd3, 16'd15);
        drv(1'b0, 5'h02, 1'b0, 3'd0, 1'b0); chk(5'h01, 5'h1F, 5'h1D, 1'b1, 1'b0, 1'b0, 16'd3, 16'd16);

        // Refill the pipe from a sparse state.
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h02, 5'h1F, 5'h1A, 1'b1, 1'b0, 1'b0, 16'd3, 16'd16);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h05, 5'h1F, 5'h14, 1'b1, 1'b0, 1'b0, 16'd3, 16'd16);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h0B, 5'h1F, 5'h08, 1'b1, 1'b0, 1'b0, 16'd3, 16'd16);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h17, 5'h1F, 5'h10, 1'b1, 1'b1, 1'b0, 16'd3, 16'd16);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h0F, 5'h1F, 5'h00, 1'b1, 1'b0, 1'b0, 16'd3, 16'd17);

        // Flush stages 0..2 together with stall_req[1]: stages 3-4 still advance.
        drv(1'b1, 5'h02, 1'b1, 3'd2, 1'b0); chk(5'h1F, 5'h1F, 5'h0F, 1'b0, 1'b1, 1'b0, 16'd3, 16'd17);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h10, 5'h1F, 5'h1F, 1'b1, 1'b1, 1'b0, 16'd4, 16'd18);

        // flush_upto=7 is clamped to stage 4: the whole pipe is flushed and nothing retires.
        fill5(16'd4, 16'd19);
        drv(1'b1, 5'h00, 1'b1, 3'd7, 1'b0); chk(5'h1F, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd4, 16'd19);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd4, 16'd19);

        // Watchdog: stall_req[4] on a full pipe, TMO=4.
        fill5(16'd4, 16'd19);
        drv(1'b1, 5'h10, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 16'd4, 16'd19);
        drv(1'b1, 5'h10, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 16'd5, 16'd19);
        drv(1'b1, 5'h10, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 16'd6, 16'd19);
        drv(1'b1, 5'h10, 1'b0, 3'd0, 1'b0); chk(5'h1F, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 16'd7, 16'd19);
        // Stall dropped, cnt_clr issued together with a retire.
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b1); chk(5'h1F, 5'h1F, 5'h01, 1'b1, 1'b1, 1'b1, 16'd8, 16'd19);
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1E, 5'h1F, 5'h03, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h1C, 5'h1F, 5'h06, 1'b1, 1'b1, 1'b1, 16'd0, 16'd1);

        // Reset dropped mid-cycle while instructions are in flight.
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0);
        #2;
        rstn = 1'b0;
        chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        drv(1'b1, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        #1;
        fetch_valid = 1'b0;
        rstn        = 1'b1;
        drv(1'b0, 5'h00, 1'b0, 3'd0, 1'b0); chk(5'h00, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);

        // Let the monitor drain the final entry.
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
            errors += exp_q.size();
            checks += exp_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit for the run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation reached time limit, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
